// File: rtl/bsg_asic_clk_gen.sv
// Generates the board-driven core and io clocks for the ASIC from one fast clock.
// Each channel is a programmable half-period divider; reconfiguration lands on a falling edge.
module bsg_asic_clk_gen #(
    parameter int div_width_p     = 8,
    parameter int core_div_init_p = 4,
    parameter int io_div_init_p   = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   cfg_v_i,
    input  logic                   cfg_sel_i,
    input  logic [div_width_p-1:0] cfg_div_i,
    input  logic                   cfg_en_i,
    output logic                   cfg_ready_o,
    output logic                   core_clk_o,
    output logic                   io_clk_o,
    output logic                   core_running_o,
    output logic                   io_running_o
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        PENDING = 2'd2
    } state_e;

    // Index 0 is the core channel, index 1 the io channel.
    state_e                 state_r    [2];
    state_e                 state_n    [2];
    logic                   clk_r      [2];
    logic                   clk_n      [2];
    logic [div_width_p-1:0] cnt_r      [2];
    logic [div_width_p-1:0] cnt_n      [2];
    logic [div_width_p-1:0] div_r      [2];
    logic [div_width_p-1:0] div_n      [2];
    logic [div_width_p-1:0] pend_div_r [2];
    logic [div_width_p-1:0] pend_div_n [2];
    logic                   pend_en_r  [2];
    logic                   pend_en_n  [2];

    logic                   cfg_accept;
    logic [div_width_p-1:0] cfg_div_capt;
    logic [1:0]             hit;
    logic [1:0]             terminal;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                state_r[ch]    <= RUNNING;
                clk_r[ch]      <= 1'b0;
                cnt_r[ch]      <= '0;
                pend_div_r[ch] <= '0;
                pend_en_r[ch]  <= 1'b0;
            end
            div_r[0] <= div_width_p'(core_div_init_p);
            div_r[1] <= div_width_p'(io_div_init_p);
        end else begin
            state_r    <= state_n;
            clk_r      <= clk_n;
            cnt_r      <= cnt_n;
            div_r      <= div_n;
            pend_div_r <= pend_div_n;
            pend_en_r  <= pend_en_n;
        end
    end

    always_comb begin
        state_n    = state_r;
        clk_n      = clk_r;
        cnt_n      = cnt_r;
        div_n      = div_r;
        pend_div_n = pend_div_r;
        pend_en_n  = pend_en_r;
        hit        = '0;
        terminal   = '0;

        cfg_ready_o  = (state_r[0] != PENDING) && (state_r[1] != PENDING);
        cfg_accept   = cfg_v_i && cfg_ready_o;
        cfg_div_capt = (cfg_div_i == '0) ? div_width_p'(1) : cfg_div_i;

        for (int unsigned ch = 0; ch < 2; ch++) begin
            hit[ch]      = cfg_accept && (cfg_sel_i == ch[0]);
            terminal[ch] = (cnt_r[ch] == div_r[ch] - 1'b1);

            // Free-running count; overridden below where a state needs otherwise.
            if (terminal[ch]) begin
                clk_n[ch] = ~clk_r[ch];
                cnt_n[ch] = '0;
            end else begin
                cnt_n[ch] = cnt_r[ch] + 1'b1;
            end

            unique case (state_r[ch])
                STOPPED: begin
                    clk_n[ch] = 1'b0;
                    cnt_n[ch] = '0;
                    if (hit[ch]) begin
                        div_n[ch]   = cfg_div_capt;
                        state_n[ch] = cfg_en_i ? RUNNING : STOPPED;
                    end
                end
                RUNNING: begin
                    if (hit[ch]) begin
                        state_n[ch]    = PENDING;
                        pend_div_n[ch] = cfg_div_capt;
                        pend_en_n[ch]  = cfg_en_i;
                    end
                end
                PENDING: begin
                    // Apply only on the falling toggle so no pulse is truncated.
                    if (terminal[ch] && clk_r[ch]) begin
                        clk_n[ch]   = 1'b0;
                        cnt_n[ch]   = '0;
                        div_n[ch]   = pend_div_r[ch];
                        state_n[ch] = pend_en_r[ch] ? RUNNING : STOPPED;
                    end
                end
                default: begin
                    state_n[ch] = STOPPED;
                    clk_n[ch]   = 1'b0;
                    cnt_n[ch]   = '0;
                end
            endcase
        end
    end

    assign core_clk_o     = clk_r[0];
    assign io_clk_o       = clk_r[1];
    assign core_running_o = (state_r[0] != STOPPED);
    assign io_running_o   = (state_r[1] != STOPPED);

endmodule

// File: tb/tb_bsg_asic_clk_gen.sv
// Self-checking bench for bsg_asic_clk_gen: directed scenarios plus random config
// traffic, compared every cycle against a countdown-based behavioural model.
module tb_bsg_asic_clk_gen;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic         cfg_v_i;
    logic         cfg_sel_i;
    logic [W-1:0] cfg_div_i;
    logic         cfg_en_i;
    logic         cfg_ready_o;
    logic         core_clk_o;
    logic         io_clk_o;
    logic         core_running_o;
    logic         io_running_o;

    always #5 clk_i = ~clk_i;

    bsg_asic_clk_gen #(
        .div_width_p    (W),
        .core_div_init_p(4),
        .io_div_init_p  (4)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .cfg_v_i       (cfg_v_i),
        .cfg_sel_i     (cfg_sel_i),
        .cfg_div_i     (cfg_div_i),
        .cfg_en_i      (cfg_en_i),
        .cfg_ready_o   (cfg_ready_o),
        .core_clk_o    (core_clk_o),
        .io_clk_o      (io_clk_o),
        .core_running_o(core_running_o),
        .io_running_o  (io_running_o)
    );

    int total = 0;
    int bad   = 0;

    // Model: per channel, output level, cycles left until the next toggle,
    // half-period, running flag, and an optional queued (div, en) update.
    int m_div  [2];
    int m_rem  [2];
    int m_pdiv [2];
    bit m_lvl  [2];
    bit m_run  [2];
    bit m_pend [2];
    bit m_pen  [2];

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_div[c]  = 4;
            m_rem[c]  = 4;
            m_lvl[c]  = 1'b0;
            m_run[c]  = 1'b1;
            m_pend[c] = 1'b0;
            m_pdiv[c] = 0;
            m_pen[c]  = 1'b0;
        end
    endfunction

    function automatic bit model_ready();
        return !m_pend[0] && !m_pend[1];
    endfunction

    // Advance the model by one clk_i rising edge using the inputs present at that edge.
    function automatic void model_edge();
        bit acc;
        int d;
        if (reset_i) begin
            model_reset();
            return;
        end
        acc = cfg_v_i && model_ready();
        d   = (cfg_div_i == 0) ? 1 : int'(cfg_div_i);
        for (int c = 0; c < 2; c++) begin
            bit tgt;
            tgt = acc && (int'(cfg_sel_i) == c);
            if (!m_run[c]) begin
                if (tgt) begin
                    m_div[c] = d;
                    m_rem[c] = d;
                    m_lvl[c] = 1'b0;
                    m_run[c] = cfg_en_i;
                end
            end else begin
                if (m_rem[c] == 1) begin
                    if (m_lvl[c] && m_pend[c]) begin
                        m_lvl[c]  = 1'b0;
                        m_div[c]  = m_pdiv[c];
                        m_rem[c]  = m_pdiv[c];
                        m_run[c]  = m_pen[c];
                        m_pend[c] = 1'b0;
                    end else begin
                        m_lvl[c] = !m_lvl[c];
                        m_rem[c] = m_div[c];
                    end
                end else begin
                    m_rem[c]--;
                end
                if (tgt) begin
                    m_pend[c] = 1'b1;
                    m_pdiv[c] = d;
                    m_pen[c]  = cfg_en_i;
                end
            end
        end
    endfunction

    // One clock: drive inputs (we are at a negedge), step model on posedge, compare #1 later.
    task automatic cycle(input bit v, input bit sel, input int div, input bit en, input bit rst);
        reset_i   = rst;
        cfg_v_i   = v;
        cfg_sel_i = sel;
        cfg_div_i = W'(div);
        cfg_en_i  = en;
        @(posedge clk_i);
        model_edge();
        #1;
        check("core_clk",     int'(core_clk_o),     int'(m_lvl[0]));
        check("io_clk",       int'(io_clk_o),       int'(m_lvl[1]));
        check("core_running", int'(core_running_o), int'(m_run[0]));
        check("io_running",   int'(io_running_o),   int'(m_run[1]));
        check("cfg_ready",    int'(cfg_ready_o),    int'(model_ready()));
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // Advance until the core model reaches the given phase position (bounded).
    task automatic wait_core(input bit lvl, input int rem);
        int n;
        n = 0;
        while (!(m_lvl[0] == lvl && m_rem[0] == rem) && n < 100) begin
            idle(1);
            n++;
        end
        check("wait_core_bound", int'(n < 100), 1);
    endtask

    initial begin
        int n;
        reset_i   = 1'b1;
        cfg_v_i   = 1'b0;
        cfg_sel_i = 1'b0;
        cfg_div_i = '0;
        cfg_en_i  = 1'b0;
        model_reset();
        @(negedge clk_i);

        // Reset defaults, then both channels free-run with period 8.
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(20);

        // Core div 4 -> 2 requested in the 2nd cycle of a high phase.
        wait_core(1'b1, 3);
        cycle(1'b1, 1'b0, 2, 1'b1, 1'b0);
        idle(16);

        // Back to div 4, then stop it from within a low phase.
        cycle(1'b1, 1'b0, 4, 1'b1, 1'b0);
        idle(12);
        wait_core(1'b0, 3);
        cycle(1'b1, 1'b0, 4, 1'b0, 1'b0);
        idle(20);

        // Restart stopped core at div 1.
        cycle(1'b1, 1'b0, 1, 1'b1, 1'b0);
        idle(10);

        // io divisor 0 behaves as 1.
        cycle(1'b1, 1'b1, 0, 1'b1, 1'b0);
        idle(12);

        // io pending with a core request held; then reset while a change is pending.
        cycle(1'b1, 1'b1, 6, 1'b1, 1'b0);
        n = 0;
        while (m_pend[1] && n < 100) begin
            cycle(1'b1, 1'b0, 3, 1'b1, 1'b0);
            n++;
        end
        check("io_apply_bound", int'(n < 100), 1);
        cycle(1'b1, 1'b0, 3, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 5, 1'b1, 1'b0);
        idle(1);
        cycle(1'b0, 1'b0, 0, 1'b0, 1'b1);
        idle(12);

        // Random configuration traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rv, rs, re, rr;
            int rd;
            rv = ($urandom_range(0, 5) == 0);
            rs = 1'($urandom_range(0, 1));
            rd = $urandom_range(0, 6);
            re = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 299) == 0);
            cycle(rv, rs, rd, re, rr);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_asic_clk_gen.md
Name: bsg_asic_clk_gen

Overview:
- FPGA-side generator of the core and io clocks that the board drives into the ASIC.
- The ASIC-side clock input buffering consumes these clocks.
- Derives two independently divided square waves from one fast clk_i; all logic is in this single domain.
- Divisor and enable change through a valid/ready config port; each change is applied glitch-free at a falling-edge boundary.
- Outputs are registered and feed ODDR/output-pin logic.

Parameters:
- div_width_p, 8: width of the half-period divisor.
- core_div_init_p, 4: core channel half-period (clk_i cycles) after reset.
- io_div_init_p, 4: io channel half-period (clk_i cycles) after reset.

Ports:
- clk_i  in  1  fast source clock; all state is updated on its posedge.
- reset_i  in  1  synchronous, active-high reset.
- cfg_v_i  in  1  config request valid.
- cfg_sel_i  in  1  target channel: 0 = core, 1 = io.
- cfg_div_i  in  div_width_p  new half-period D.
- cfg_en_i  in  1  1 = run after update, 0 = stop.
- cfg_ready_o  out  1  config request can be accepted.
- core_clk_o  out  1  generated core clock (registered).
- io_clk_o  out  1  generated io clock (registered).
- core_running_o  out  1  core channel not stopped.
- io_running_o  out  1  io channel not stopped.

Behaviour:
- Each channel holds: clk_r, cnt (div_width_p bits), div, state ∈ {STOPPED, RUNNING, PENDING}, plus pend_div and pend_en.
- Reset values, both channels:
  - clk_r = 0, cnt = 0, state = RUNNING.
  - div = core_div_init_p (core) or io_div_init_p (io).
  - Result: cfg_ready_o = 1, running outputs = 1, clock outputs = 0.
- A reset asserted mid-operation, including in PENDING, discards any pending config and returns the channel to the reset state.
- Counting in RUNNING or PENDING:
  - If cnt == div-1: clk_r toggles and cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - Output period = 2·div clk_i cycles at 50% duty.
  - After reset the first rise of the output is visible after div posedges.
- A cfg_div_i of 0 is coerced to 1 when captured.
- Handshake:
  - cfg_ready_o = 1 iff neither channel is in PENDING. It does not depend on cfg_sel_i.
  - A transfer occurs on a posedge with cfg_v_i & cfg_ready_o. Fields are captured that cycle.
- Acceptance when the target channel is STOPPED:
  - Next cycle div = captured divisor, cnt = 0, clk_r = 0.
  - state = RUNNING if cfg_en_i, else it stays STOPPED.
- Acceptance when the target channel is RUNNING:
  - state <= PENDING; the divisor and enable are stored in pend_div and pend_en.
  - The channel keeps counting with the old div.
- Leaving PENDING happens on the posedge where clk_r = 1 and cnt == div-1 (the falling toggle). On that edge:
  - clk_r <= 0, cnt <= 0, div <= pend_div.
  - state <= RUNNING if pend_en, else STOPPED.
  - A PENDING entered during the low phase waits for the next full high phase to complete.
  - No output pulse is ever shorter than min(old, new) div cycles.
- STOPPED: clk_r is held at 0 and cnt is held at 0.
- running_o = (state != STOPPED). It falls on the same edge as the final falling toggle.
- The other channel is unaffected by any config targeting one channel.
- A cfg_v_i held while cfg_ready_o = 0 is not consumed; it is accepted once ready returns.

Test Plan:
- Reset with defaults → core_clk_o and io_clk_o are 0 for 4 cycles, then 1 for 4; period 8; both running outputs = 1 and cfg_ready_o = 1.
- Core running at div 4: send div 2, en 1 in the 2nd cycle of a high phase → cfg_ready_o = 0 until the falling edge. That high phase lasts the full 4 cycles, then the period is 4. io_clk_o is unchanged throughout.
- Core running at div 4: send en 0 during a low phase → the low phase completes, one more full 4-cycle high pulse follows, then core_clk_o = 0 and core_running_o = 0 on the same edge, and the output stays low.
- Core stopped: send div 1, en 1 → core_clk_o toggles every cycle, first high 1 cycle after the update; core_running_o = 1.
- Send div 0 to io → io behaves as div 1 (period 2).
- io in PENDING with cfg_v_i held targeting core → no accept until io applies. Then assert reset_i mid-pending → both channels return to defaults, cfg_ready_o = 1, and the pending io config is discarded.
